mem_stage_pipe: RTL

- Parametrised, pipelined successor to the single-cycle memory stage: a data memory with a result mux (ALU result vs. memory read) feeding writeback.
- Adds configurable width and depth, a registered valid/ready handshake with backpressure, byte-mode accesses with zero or sign extension, and a post-reset memory-clear sequencer.
- Sits between the ALU and the register-file writeback in the core pipeline.

---
 rtl/mem_stage_pipe.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_pipe.sv
// ---------------------------------------------------------------------------------------------
// mem_stage_pipe
//
// Pipelined memory stage that sits between the ALU and register-file writeback. It holds a
// 2**ADDR_W x DATA_W data memory. Each accepted operation may store to the memory. The stage
// registers either the memory read data or the ALU result as the writeback value one cycle
// after acceptance.
//
// After reset, a clear sequencer walks every memory entry and writes zero. No operation is
// accepted until it has finished.
//
// Parameters
//   DATA_W     data / ALU-result width (must be > 8)
//   ADDR_W     address bits; memory depth is 2**ADDR_W
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   IN_VALID   upstream presents an operation
//   IN_READY   stage accepts the operation this cycle
//   ALUIN      ALU result; low ADDR_W bits form the memory address
//   WD         store data
//   WE         store enable
//   MR         writeback select: 1 = memory read data, 0 = ALUIN
//   MODE       00/11 = word, 01 = byte zero-extend, 10 = byte sign-extend
//   OUT        registered writeback value
//   OUT_VALID  OUT holds a valid result
//   OUT_READY  downstream consumes OUT
//   BUSY       memory-clear sequence in progress
// ---------------------------------------------------------------------------------------------
module mem_stage_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] ALUIN,
    input  logic [DATA_W-1:0] WD,
    input  logic              WE,
    input  logic              MR,
    input  logic [1:0]        MODE,
    output logic [DATA_W-1:0] OUT,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              BUSY
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;

    logic               clr_en;
    logic               run;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: INIT spends exactly one cycle per memory entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = '0;
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        clr_en = 1'b0;
        run    = 1'b0;
        unique case (state_q)
            StInit:  clr_en = 1'b1;
            StRun:   run    = 1'b1;
            default: clr_en = 1'b1;
        endcase
    end

    assign BUSY = clr_en;

    // ---------------------------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------------------------
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              accept;

    // A new operation fits whenever the output slot is empty or is being drained this cycle.
    assign IN_READY = run && (!out_valid_q || OUT_READY);
    assign accept   = IN_VALID && IN_READY;

    // ---------------------------------------------------------------------------------------
    // Memory access
    // ---------------------------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [Depth];

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rword;
    logic [DATA_W-1:0] rdata;
    logic              byte_mode;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Upper ALUIN bits are ignored, so addresses alias modulo the depth.
    assign addr      = ALUIN[ADDR_W-1:0];
    assign rword     = mem_q[addr];
    assign byte_mode = (MODE == 2'b01) || (MODE == 2'b10);

    always_comb begin
        rdata = rword;
        unique case (MODE)
            2'b01:   rdata = {{(DATA_W - 8){1'b0}}, rword[7:0]};
            2'b10:   rdata = {{(DATA_W - 8){rword[7]}}, rword[7:0]};
            default: rdata = rword;
        endcase
    end

    // The clear sequencer owns the write port in INIT; in RUN only accepted stores write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = WD;
        if (clr_en) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (accept && WE) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            // Byte stores merge into the existing word, keeping the upper bits.
            mem_wdata = byte_mode ? {rword[DATA_W-1:8], WD[7:0]} : WD;
        end
    end

    // Memory array has no reset; the INIT sequence provides the known contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Output register
    // ---------------------------------------------------------------------------------------
    // rword is sampled before the edge that performs a same-cycle write, so a combined
    // store+load returns the old contents.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_d       = MR ? rdata : ALUIN;
            out_valid_d = 1'b1;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OUT       = out_q;
    assign OUT_VALID = out_valid_q;

endmodule
